// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner.
// One active-low column is driven at a time. The rows are sampled once per
// scan step, and presses and releases are debounced. Keys do not roll over:
// once a key is a candidate, every other key is ignored until it is released.
module keypad_scanner #(
  parameter logic [15:0] T1MS    = 16'd50000,
  parameter int          DEB_CNT = 4
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic [3:0] Row_In,
  output logic [3:0] Col_Out,
  output logic [3:0] Key_Code,
  output logic       Key_Valid,
  output logic       Key_Down
);

  localparam logic [7:0] DEB = 8'(DEB_CNT);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HOLD
  } state_e;

  state_e      state_q;
  logic [3:0]  row_meta_q;
  logic [3:0]  row_s_q;
  logic [15:0] tick_cnt_q;
  logic [15:0] tick_cnt_d;
  logic        tick;
  logic [1:0]  col_q;
  logic [1:0]  row_q;
  logic [7:0]  press_cnt_q;
  logic [7:0]  rel_cnt_q;
  logic [7:0]  press_inc;
  logic [7:0]  rel_inc;
  logic [3:0]  key_code_q;
  logic        key_valid_q;
  logic        key_down_q;
  logic        any_low;
  logic [1:0]  low_row;

  // Two-flop synchronizer for the asynchronous, externally pulled-up rows.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      row_meta_q <= 4'b1111;
      row_s_q    <= 4'b1111;
    end else begin
      row_meta_q <= Row_In;
      row_s_q    <= row_meta_q;
    end
  end

  // Scan step timebase: the counter wraps so that one tick occurs every T1MS cycles.
  always_comb begin
    tick       = (tick_cnt_q == (T1MS - 16'd1));
    tick_cnt_d = tick ? 16'd0 : (tick_cnt_q + 16'd1);
  end

  // Timebase register.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      tick_cnt_q <= 16'd0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // Lowest-index active row wins when several rows are pulled low together.
  always_comb begin
    any_low = (row_s_q != 4'b1111);
    low_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_s_q[i]) begin
        low_row = 2'(i);
      end
    end
  end

  // Incremented debounce counts, compared against DEB_CNT before they are stored.
  always_comb begin
    press_inc = press_cnt_q + 8'd1;
    rel_inc   = rel_cnt_q + 8'd1;
  end

  // Scan, debounce and hold sequencing. Every output is a register.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= SCAN;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      press_cnt_q <= 8'd0;
      rel_cnt_q   <= 8'd0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (tick) begin
        case (state_q)
          SCAN: begin
            if (!any_low) begin
              col_q <= col_q + 2'd1;
            end else begin
              row_q       <= low_row;
              press_cnt_q <= 8'd1;
              if (DEB == 8'd1) begin
                state_q     <= HOLD;
                key_code_q  <= {low_row, col_q};
                key_valid_q <= 1'b1;
                key_down_q  <= 1'b1;
                rel_cnt_q   <= 8'd0;
              end else begin
                state_q <= DEBOUNCE;
              end
            end
          end
          DEBOUNCE: begin
            if (!row_s_q[row_q]) begin
              press_cnt_q <= press_inc;
              if (press_inc == DEB) begin
                state_q     <= HOLD;
                key_code_q  <= {row_q, col_q};
                key_valid_q <= 1'b1;
                key_down_q  <= 1'b1;
                rel_cnt_q   <= 8'd0;
              end
            end else begin
              state_q     <= SCAN;
              press_cnt_q <= 8'd0;
              col_q       <= col_q + 2'd1;
            end
          end
          HOLD: begin
            if (row_s_q[row_q]) begin
              rel_cnt_q <= rel_inc;
              if (rel_inc == DEB) begin
                state_q     <= SCAN;
                key_down_q  <= 1'b0;
                rel_cnt_q   <= 8'd0;
                press_cnt_q <= 8'd0;
                col_q       <= col_q + 2'd1;
              end
            end else begin
              rel_cnt_q <= 8'd0;
            end
          end
          default: begin
            state_q <= SCAN;
          end
        endcase
      end
    end
  end

  assign Col_Out   = ~(4'b0001 << col_q);
  assign Key_Code  = key_code_q;
  assign Key_Valid = key_valid_q;
  assign Key_Down  = key_down_q;

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL have parameter T1MS, default 16'd50000, giving the clock cycles per column scan step (1 ms at 50 MHz).
REQ-002 The block SHALL have parameter DEB_CNT, default 4, giving the consecutive matching scan ticks required to accept a press or a release.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-004 The block SHALL have port RST_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port Row_In, input, 4 bits: keypad row sense lines, active-low, pulled up externally, asynchronous to CLK.
REQ-006 The block SHALL have port Col_Out, output, 4 bits: keypad column drive, active-low one-hot.
REQ-007 The block SHALL have port Key_Code, output, 4 bits: code of the last accepted key.
REQ-008 The block SHALL have port Key_Valid, output, 1 bit: a one-cycle pulse on each accepted press.
REQ-009 The block SHALL have port Key_Down, output, 1 bit: high while the accepted key is held.

Function
REQ-010 Row_In SHALL pass through a 2-flop synchronizer, and all decisions SHALL use the synchronized value (Row_S).
REQ-011 A 16-bit counter SHALL count 0..T1MS-1 and wrap; "tick" SHALL be the cycle in which the counter equals T1MS-1, giving a period of exactly T1MS cycles.
REQ-012 Column index c (0..3) SHALL map to Col_Out = ~(1<<c): 0->1110, 1->1101, 2->1011, 3->0111.
REQ-013 "Advance" SHALL mean c <= c+1 mod 4 (3 wraps to 0) at the tick edge.
REQ-014 Row_S SHALL be evaluated only in tick cycles, and Col_Out SHALL change only on tick edges, so each column is driven for at least T1MS cycles before it is sampled.
REQ-015 The FSM SHALL have exactly three states: SCAN, DEBOUNCE and HOLD.
REQ-016 In SCAN at a tick with Row_S==4'b1111, the block SHALL advance.
REQ-017 In SCAN at a tick with any row bit low, the block SHALL latch candidate row r (lowest-index low bit wins), hold c, set the press counter to 1 and enter DEBOUNCE.
REQ-018 In DEBOUNCE at each tick with Row_S[r]==0, the press counter SHALL increment; when it reaches DEB_CNT, the block SHALL enter HOLD.
REQ-019 On entry to HOLD, the block SHALL register Key_Code = 4*r + c, pulse Key_Valid high for exactly one cycle, and set Key_Down=1.
REQ-020 In DEBOUNCE at a tick with Row_S[r]==1, the block SHALL return to SCAN and advance, with no Key_Valid.
REQ-021 In HOLD, the column SHALL be held; at each tick, Row_S[r]==1 SHALL increment the release counter and Row_S[r]==0 SHALL clear it.
REQ-022 In HOLD, when the release counter reaches DEB_CNT, the block SHALL clear Key_Down, return to SCAN and advance.
REQ-023 Presses of other rows or columns SHALL be ignored while in DEBOUNCE or HOLD (no rollover).
REQ-024 Key_Code SHALL retain its last value until the next accepted press.
REQ-025 With DEB_CNT==1, a press SHALL be accepted at the first low tick (SCAN goes directly to HOLD), and a release SHALL be accepted at the first high tick.
REQ-026 Key_Valid SHALL never be high for two consecutive cycles.

Reset
REQ-027 While RST_n==0, and immediately (asynchronously), the block SHALL force: state SCAN, c=0, Col_Out=4'b1110, Key_Code=4'h0, Key_Valid=0, Key_Down=0, both counters 0, synchronizer flops 4'b1111.
REQ-028 Reset asserted in any state, including mid-DEBOUNCE and mid-HOLD, SHALL abort the operation without emitting Key_Valid.
REQ-029 After RST_n rises, the first tick SHALL occur T1MS cycles later.

Verification (T1MS=10, DEB_CNT=3)
REQ-030 Idle: Row_In=1111 -> Col_Out steps 1110,1101,1011,0111,1110 every 10 cycles; Key_Valid stays 0.
REQ-031 Press: drive Row_In=1101 whenever Col_Out==1011 and hold it -> exactly one Key_Valid pulse, Key_Code=6, Key_Down=1, and Col_Out stays 1011.
REQ-032 Release: from REQ-031, set Row_In=1111 -> Key_Down falls at the 3rd tick, and Col_Out becomes 0111 at that tick edge.
REQ-033 Bounce: at column 0, hold Row_In=1110 for 2 ticks, then 1111 -> no Key_Valid, Key_Code unchanged, and scanning resumes at column 1.
REQ-034 Multi-row: at column 0, hold Row_In=1001 -> Key_Code=4 (r=1, c=0).
REQ-035 Reset: assert RST_n=0 mid-HOLD -> Key_Down=0, Col_Out=1110 and Key_Code=0 without waiting for a clock edge, and no Key_Valid is emitted.
